lsu: RTL and testbench
======================

# lsu

Load/store unit in the memory stage of the npc core, directly downstream of instruction decode. It consumes the decoder's `Mem_wr` / `Mem_bits` controls together with the ALU-computed address and the store data. It runs one single-beat transaction on a valid/ready memory bus per request, then returns a sign- or zero-extended load result to writeback. Unaligned or illegal requests are rejected without touching the bus.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. Fixed at 32; byte lanes are derived for 4 lanes.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req_valid` input 1: memory request from execute.
- `req_ready` output 1: LSU can accept a request.
- `req_wr` input 1: 1 = store, 0 = load. Driven by decoder `Mem_wr`.
- `req_bits` input 3: width/sign code, equal to RV32 funct3. Driven by decoder `Mem_bits`.
- `req_addr` input ADDR_W: byte address from the ALU.
- `req_wdata` input DATA_W: store data (rs2), LSB-aligned.
- `resp_valid` output 1: one-cycle pulse that completes the request.
- `resp_rdata` output DATA_W: extended load data; 0 for stores and errors.
- `resp_err` output 1: request was misaligned or had an illegal `req_bits`.
- `bus_req_valid` output 1: bus request.
- `bus_req_ready` input 1: bus accepts the request.
- `bus_addr` output ADDR_W: word-aligned address (`req_addr & ~3`).
- `bus_wen` output 1: write enable.
- `bus_wstrb` output 4: byte strobes; 0 on reads.
- `bus_wdata` output DATA_W: lane-positioned write data.
- `bus_resp_valid` input 1: bus read data valid or write acknowledge.
- `bus_rdata` input DATA_W: raw read word.

## Operation
- States:
  - IDLE: `req_ready` = 1.
  - REQ: `bus_req_valid` = 1, bus outputs stable.
  - WAIT: waiting for `bus_resp_valid`.
  - RESP: `resp_valid` = 1.
- Request capture:
  - Request registers are loaded on `req_valid && req_ready`.
  - IDLE→REQ for a legal, aligned request.
  - IDLE→RESP with `resp_err` = 1 otherwise.
- Legal `req_bits`:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other code is an error; stores with bit 2 set are errors.
- Alignment: a halfword needs `addr[0]` = 0; a word needs `addr[1:0]` = 0.
- State transitions:
  - REQ→WAIT on `bus_req_ready`.
  - WAIT→RESP on `bus_resp_valid`; the extended result is registered on this edge.
  - RESP→IDLE unconditionally.
- Store strobes:
  - sb: `4'b0001 << addr[1:0]`, with the byte replicated on all lanes.
  - sh: `4'b0011 << addr[1:0]`, with the halfword replicated.
  - sw: `4'b1111`.
- Load extraction:
  - Byte = `bus_rdata >> (8*addr[1:0])`.
  - Halfword = `bus_rdata >> (16*addr[1])`.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- `bus_resp_valid` outside WAIT is ignored. The bus must not respond in the cycle of request acceptance.
- No response backpressure: writeback must sample `resp_valid` on the cycle it is high.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready` = 1.
  - `resp_valid`, `resp_err`, `resp_rdata`, `bus_req_valid`, `bus_wen`, `bus_wstrb`, `bus_addr`, `bus_wdata` = 0.
- Minimum latency is 3 cycles from the accept edge to `resp_valid` (REQ, WAIT, RESP), given `bus_req_ready` in the first REQ cycle and `bus_resp_valid` in the first WAIT cycle.
- Error path: `resp_valid` is high 1 cycle after accept. No bus activity.
- Back-to-back throughput: a new request is accepted in the cycle after RESP.
- Reset in any state immediately returns to IDLE and drops `bus_req_valid`. A late bus response arriving after reset is ignored.
- Bus outputs are driven from registers, so there is no combinational path from `req_*` to `bus_*`.

## Structure
- `lsu_pkg` holds:
  - the state enum;
  - `req_bits` localparams (`LB`, `LH`, `LW`, `LBU`, `LHU`);
  - width constants.
- Sub-module `lsu_align` is purely combinational. It computes `bus_wstrb`, `bus_wdata`, the misalign/illegal flag and the load extension from `req_bits`, `addr[1:0]`, `wdata` and `rdata`.
- `lsu` itself holds the FSM and the request/response registers.

## Test plan
- lw, addr 0x80000004, bus returns 0x12345678 with zero wait states → `bus_addr` = 0x80000004, `resp_rdata` = 0x12345678, `resp_valid` 3 cycles after accept.
- lb at 0x80000003, rdata 0x80FF0011 → `resp_rdata` = 0xFFFFFF80; same access as lbu → 0x00000080.
- sh, addr 0x80000002, wdata 0x0000BEEF → `bus_wstrb` = 4'b1100, `bus_wdata` = 0xBEEFBEEF, `bus_wen` = 1, `resp_rdata` = 0.
- lw at 0x80000002 → `resp_err` = 1 one cycle after accept, `bus_req_valid` never asserted. Also send a store with `req_bits` = 100 → `resp_err` = 1.
- `bus_req_ready` held low 3 cycles, then 2-cycle response delay → bus outputs stable throughout REQ, exactly one `resp_valid` pulse.
- `rst` asserted while in WAIT, then `bus_resp_valid` pulses → all outputs 0, no `resp_valid`, `req_ready` = 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;
    localparam int BYTE_W = 8;

    // req_bits codes, identical to RV32 load/store funct3
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request/response and memory-bus interfaces of the load/store unit
interface lsu_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [2:0]        req_bits;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wr, req_bits, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_bits, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req_valid;
    logic              bus_req_ready;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_wen;
    logic [3:0]        bus_wstrb;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_resp_valid;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req_valid, bus_addr, bus_wen, bus_wstrb, bus_wdata,
        input  bus_req_ready, bus_resp_valid, bus_rdata
    );

    modport slave (
        input  bus_req_valid, bus_addr, bus_wen, bus_wstrb, bus_wdata,
        output bus_req_ready, bus_resp_valid, bus_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane placement, legality check and load extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic              wr,
    input  logic [2:0]        bits,
    input  logic [1:0]        off,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rdata,
    output logic [LANES-1:0]  wstrb,
    output logic [WORD_W-1:0] wlane,
    output logic              err,
    output logic [WORD_W-1:0] rext
);

    logic [BYTE_W-1:0]   rbyte;
    logic [2*BYTE_W-1:0] rhalf;
    logic                illegal;
    logic                misalign;

    always_comb begin
        rbyte = rdata[{off, 3'b000} +: BYTE_W];
        rhalf = off[1] ? rdata[31:16] : rdata[15:0];

        // stores only have sb/sh/sw; loads additionally allow the unsigned variants
        if (wr) begin
            illegal = bits[2] || (bits[1:0] == 2'b11);
        end else begin
            illegal = (bits[1:0] == 2'b11) || (bits[2:1] == 2'b11);
        end
        misalign = ((bits[1:0] == 2'b01) && off[0]) ||
                   ((bits[1:0] == 2'b10) && (off != 2'b00));
        err = illegal || misalign;

        wstrb = '0;
        wlane = '0;
        if (wr) begin
            case (bits[1:0])
                2'b00: begin
                    wstrb = 4'b0001 << off;
                    wlane = {4{wdata[7:0]}};
                end
                2'b01: begin
                    wstrb = 4'b0011 << off;
                    wlane = {2{wdata[15:0]}};
                end
                default: begin
                    wstrb = 4'b1111;
                    wlane = wdata;
                end
            endcase
        end

        case (bits)
            LB:      rext = {{24{rbyte[7]}}, rbyte};
            LH:      rext = {{16{rhalf[15]}}, rhalf};
            LW:      rext = rdata;
            LBU:     rext = {24'd0, rbyte};
            LHU:     rext = {16'd0, rhalf};
            default: rext = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - memory-stage load/store unit: request FSM and registered bus/response outputs
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    lsu_req_if.slave  req,
    lsu_bus_if.master bus
);

    state_t            state;
    logic              ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              bus_req_valid_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic              bus_wen_q;
    logic [3:0]        bus_wstrb_q;
    logic [DATA_W-1:0] bus_wdata_q;

    logic              wr_q;
    logic [2:0]        bits_q;
    logic [1:0]        off_q;

    logic              a_wr;
    logic [2:0]        a_bits;
    logic [1:0]        a_off;
    logic [LANES-1:0]  a_wstrb;
    logic [WORD_W-1:0] a_wlane;
    logic              a_err;
    logic [WORD_W-1:0] a_rext;

    // One aligner serves both phases: live request while idle, captured request afterwards
    assign a_wr   = (state == ST_IDLE) ? req.req_wr        : wr_q;
    assign a_bits = (state == ST_IDLE) ? req.req_bits      : bits_q;
    assign a_off  = (state == ST_IDLE) ? req.req_addr[1:0] : off_q;

    lsu_align u_align (
        .wr    (a_wr),
        .bits  (a_bits),
        .off   (a_off),
        .wdata (req.req_wdata),
        .rdata (bus.bus_rdata),
        .wstrb (a_wstrb),
        .wlane (a_wlane),
        .err   (a_err),
        .rext  (a_rext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            ready_q         <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= '0;
            bus_req_valid_q <= 1'b0;
            bus_addr_q      <= '0;
            bus_wen_q       <= 1'b0;
            bus_wstrb_q     <= '0;
            bus_wdata_q     <= '0;
            wr_q            <= 1'b0;
            bits_q          <= '0;
            off_q           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req.req_valid && ready_q) begin
                        wr_q    <= req.req_wr;
                        bits_q  <= req.req_bits;
                        off_q   <= req.req_addr[1:0];
                        ready_q <= 1'b0;
                        if (a_err) begin
                            state        <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state           <= ST_REQ;
                            bus_req_valid_q <= 1'b1;
                            bus_addr_q      <= {req.req_addr[ADDR_W-1:2], 2'b00};
                            bus_wen_q       <= req.req_wr;
                            bus_wstrb_q     <= a_wstrb;
                            bus_wdata_q     <= a_wlane;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.bus_req_ready) begin
                        state           <= ST_WAIT;
                        bus_req_valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus.bus_resp_valid) begin
                        state        <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= wr_q ? '0 : a_rext;
                    end
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    ready_q      <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req.req_ready      = ready_q;
    assign req.resp_valid     = resp_valid_q;
    assign req.resp_err       = resp_err_q;
    assign req.resp_rdata     = resp_rdata_q;
    assign bus.bus_req_valid  = bus_req_valid_q;
    assign bus.bus_addr       = bus_addr_q;
    assign bus.bus_wen        = bus_wen_q;
    assign bus.bus_wstrb      = bus_wstrb_q;
    assign bus.bus_wdata      = bus_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - scoreboard bench for the load/store unit
module tb_lsu;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        wen;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic mon_en = 1'b1;
    logic bus_seen = 1'b0;
    exp_t exp_q[$];

    lsu_req_if #(.ADDR_W(32), .DATA_W(32)) rq ();
    lsu_bus_if #(.ADDR_W(32), .DATA_W(32)) bs ();

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .req (rq),
        .bus (bs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    function automatic exp_t mk(input logic err, input logic [31:0] rdata, input logic wen,
                                input logic [3:0] wstrb, input logic [31:0] addr,
                                input logic [31:0] wdata, input int lat);
        exp_t e;
        e.err = err; e.rdata = rdata; e.wen = wen; e.wstrb = wstrb;
        e.addr = addr; e.wdata = wdata; e.lat = lat;
        return e;
    endfunction

    function automatic exp_t model(input logic wr, input logic [2:0] bits, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata,
                                   input int rd, input int rs);
        exp_t e;
        logic [1:0]  o;
        logic [7:0]  b;
        logic [15:0] h;
        o = addr[1:0];
        b = rdata[8*o +: 8];
        h = o[1] ? rdata[31:16] : rdata[15:0];
        e = mk(1'b0, 32'h0, 1'b0, 4'h0, {addr[31:2], 2'b00}, 32'h0, 0);
        if (wr) begin
            e.wen = 1'b1;
            case (bits)
                3'd0: begin e.wstrb = 4'b0001 << o; e.wdata = {4{wdata[7:0]}}; end
                3'd1: begin e.err = o[0]; e.wstrb = 4'b0011 << o; e.wdata = {2{wdata[15:0]}}; end
                3'd2: begin e.err = (o != 2'd0); e.wstrb = 4'hF; e.wdata = wdata; end
                default: e.err = 1'b1;
            endcase
        end else begin
            case (bits)
                3'd0: e.rdata = {{24{b[7]}}, b};
                3'd4: e.rdata = {24'h0, b};
                3'd1: begin e.err = o[0]; e.rdata = {{16{h[15]}}, h}; end
                3'd5: begin e.err = o[0]; e.rdata = {16'h0, h}; end
                3'd2: begin e.err = (o != 2'd0); e.rdata = rdata; end
                default: e.err = 1'b1;
            endcase
        end
        if (e.err) begin
            e.rdata = 32'h0; e.wen = 1'b0; e.wstrb = 4'h0; e.wdata = 32'h0;
        end
        e.lat = e.err ? 1 : 3 + rd + rs;
        return e;
    endfunction

    // Drives one request and plays the memory side; the monitor below scores the outcome
    task automatic run(input logic wr, input logic [2:0] bits, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int rd, input int rs, input exp_t e);
        int n;
        exp_q.push_back(e);
        @(posedge clk); #1;
        check("req_ready_idle", {31'h0, rq.req_ready}, 32'h1);
        n = 0;
        while (!rq.req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        rq.req_valid = 1'b1; rq.req_wr = wr; rq.req_bits = bits;
        rq.req_addr = addr; rq.req_wdata = wdata;
        @(posedge clk); #1;
        acc_cyc = cyc;
        rq.req_valid = 1'b0;
        if (!e.err) begin
            for (int i = 0; i < rd; i++) begin
                check("hold_valid", {31'h0, bs.bus_req_valid}, 32'h1);
                check("hold_addr", bs.bus_addr, e.addr);
                check("hold_strb", {28'h0, bs.bus_wstrb}, {28'h0, e.wstrb});
                check("hold_wdata", bs.bus_wdata, e.wdata);
                @(posedge clk); #1;
            end
            bs.bus_req_ready = 1'b1;
            @(posedge clk); #1;
            bs.bus_req_ready = 1'b0;
            for (int i = 0; i < rs; i++) begin
                @(posedge clk); #1;
            end
            bs.bus_resp_valid = 1'b1; bs.bus_rdata = rdata;
            @(posedge clk); #1;
            bs.bus_resp_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bs.bus_req_valid && bs.bus_req_ready) begin
                if (exp_q.size() == 0) check("bus_unexpected", 32'h1, 32'h0);
                else begin
                    bus_seen = 1'b1;
                    check("bus_addr", bs.bus_addr, exp_q[0].addr);
                    check("bus_wen", {31'h0, bs.bus_wen}, {31'h0, exp_q[0].wen});
                    check("bus_wstrb", {28'h0, bs.bus_wstrb}, {28'h0, exp_q[0].wstrb});
                    check("bus_wdata", bs.bus_wdata, exp_q[0].wdata);
                end
            end
            if (rq.resp_valid) begin
                if (exp_q.size() == 0) check("resp_unexpected", 32'h1, 32'h0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_err", {31'h0, rq.resp_err}, {31'h0, e.err});
                    check("resp_rdata", rq.resp_rdata, e.rdata);
                    check("resp_latency", cyc - acc_cyc + 1, e.lat);
                    check("bus_used", {31'h0, bus_seen}, {31'h0, ~e.err});
                    bus_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        rq.req_valid = 1'b0; rq.req_wr = 1'b0; rq.req_bits = 3'd0;
        rq.req_addr = 32'h0; rq.req_wdata = 32'h0;
        bs.bus_req_ready = 1'b0; bs.bus_resp_valid = 1'b0; bs.bus_rdata = 32'h0;

        #12;
        check("rst_req_ready", {31'h0, rq.req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, rq.resp_valid}, 32'h0);
        check("rst_resp_rdata", rq.resp_rdata, 32'h0);
        check("rst_bus_valid", {31'h0, bs.bus_req_valid}, 32'h0);
        check("rst_bus_addr", bs.bus_addr, 32'h0);
        check("rst_bus_wstrb", {28'h0, bs.bus_wstrb}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        run(1'b0, 3'd2, 32'h80000004, 32'h0, 32'h12345678, 0, 0,
            mk(1'b0, 32'h12345678, 1'b0, 4'h0, 32'h80000004, 32'h0, 3));
        run(1'b0, 3'd0, 32'h80000003, 32'h0, 32'h80FF0011, 0, 0,
            mk(1'b0, 32'hFFFFFF80, 1'b0, 4'h0, 32'h80000000, 32'h0, 3));
        run(1'b0, 3'd4, 32'h80000003, 32'h0, 32'h80FF0011, 0, 0,
            mk(1'b0, 32'h00000080, 1'b0, 4'h0, 32'h80000000, 32'h0, 3));
        run(1'b1, 3'd1, 32'h80000002, 32'h0000BEEF, 32'hFFFFFFFF, 0, 0,
            mk(1'b0, 32'h0, 1'b1, 4'b1100, 32'h80000000, 32'hBEEFBEEF, 3));
        run(1'b0, 3'd2, 32'h80000002, 32'h0, 32'h0, 0, 0,
            mk(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1));
        run(1'b1, 3'd4, 32'h80000000, 32'h11223344, 32'h0, 0, 0,
            mk(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1));
        run(1'b1, 3'd2, 32'h80000008, 32'hCAFEF00D, 32'h0, 3, 2,
            mk(1'b0, 32'h0, 1'b1, 4'hF, 32'h80000008, 32'hCAFEF00D, 8));
        run(1'b0, 3'd5, 32'h80000012, 32'h0, 32'h9ABC1234, 1, 1,
            mk(1'b0, 32'h00009ABC, 1'b0, 4'h0, 32'h80000010, 32'h0, 5));

        for (int k = 0; k < 24; k++) begin
            logic        wr;
            logic [2:0]  bits;
            logic [31:0] addr, wdata, rdata;
            int          rd, rs;
            wr = 1'($urandom_range(0, 1));
            bits = 3'($urandom_range(0, 7));
            addr = 32'h80000000 | 32'($urandom_range(0, 255));
            wdata = $urandom; rdata = $urandom;
            rd = $urandom_range(0, 2); rs = $urandom_range(0, 2);
            run(wr, bits, addr, wdata, rdata, rd, rs, model(wr, bits, addr, wdata, rdata, rd, rs));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'h0);

        // Reset while waiting on the bus, then a stale response arrives
        mon_en = 1'b0;
        rq.req_valid = 1'b1; rq.req_wr = 1'b0; rq.req_bits = 3'd2;
        rq.req_addr = 32'h80000010; rq.req_wdata = 32'h0;
        @(posedge clk); #1;
        rq.req_valid = 1'b0; bs.bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bs.bus_req_ready = 1'b0;
        check("wait_bus_valid_low", {31'h0, bs.bus_req_valid}, 32'h0);
        check("wait_bus_addr", bs.bus_addr, 32'h80000010);
        rst = 1'b1;
        #1;
        check("arst_req_ready", {31'h0, rq.req_ready}, 32'h1);
        check("arst_bus_addr", bs.bus_addr, 32'h0);
        check("arst_bus_valid", {31'h0, bs.bus_req_valid}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bs.bus_resp_valid = 1'b1; bs.bus_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        bs.bus_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_resp_valid", {31'h0, rq.resp_valid}, 32'h0);
            check("late_resp_rdata", rq.resp_rdata, 32'h0);
            check("late_req_ready", {31'h0, rq.req_ready}, 32'h1);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
